bcd2bin: RTL and testbench
==========================

BCD2BIN -- requirements
Module: bcd2bin

Interface
- No parameters.
- REQ-001: clk  input  1  -- single system clock; all state SHALL update on its rising edge.
- REQ-002: rst  input  1  -- reset, synchronous, active-high.
- REQ-003: bcd  input  16  -- four packed BCD digits; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- REQ-004: start  input  1  -- conversion request; sampled only while idle.
- REQ-005: bin  output  14  -- registered binary result, range 0..9999.
- REQ-006: busy  output  1  -- high from the cycle after an accepted start until rdy is asserted.
- REQ-007: rdy  output  1  -- one-cycle pulse marking bin (and err) valid.
- REQ-008: err  output  1  -- invalid-digit flag, valid while rdy=1 and held until the next rdy.

Function
- REQ-009: Algorithm SHALL be sequential reverse double-dabble on a 30-bit work register {bcd[15:0], bin[13:0]}.
- REQ-010: States SHALL be IDLE, SHIFT, ADJ and DONE.
- REQ-011: IDLE with start=1 SHALL, at that edge:
  - load the work register with {bcd, 14'b0};
  - clear the 4-bit shift counter;
  - set busy=1;
  - go to SHIFT.
- REQ-012: SHIFT SHALL:
  - shift the whole work register right 1 bit, filling 0 at the MSB;
  - increment the counter;
  - go to DONE when the counter was 13 (14th shift), else to ADJ.
- REQ-013: ADJ SHALL subtract 3 from each 4-bit BCD digit field whose value is >= 8, all four fields evaluated in parallel, then go to SHIFT.
- REQ-014: DONE SHALL:
  - copy work[13:0] to bin;
  - pulse rdy=1 for exactly one cycle;
  - clear busy;
  - go to IDLE.
- REQ-015: Latency: start sampled at edge k SHALL give rdy=1 and a valid bin in the cycle following edge k+28 (14 SHIFT, 13 ADJ, 1 DONE).
- REQ-016: start while busy=1 or in DONE SHALL be ignored, with no queuing.
- REQ-017: A start held high SHALL be accepted again on the first IDLE cycle after DONE, giving one conversion every 29 cycles.
- REQ-018: bin SHALL hold its last value between rdy pulses; the bcd input need not be held after the accepting edge.
- REQ-019: After the final shift the BCD fields of the work register SHALL be zero for every valid input.

Reset
- REQ-020: rst=1 at an edge SHALL force, from the following cycle:
  - state=IDLE;
  - bin=0, busy=0, rdy=0, err=0;
  - counter=0 and work register=0.
- REQ-021: rst SHALL take priority over start.
- REQ-022: A conversion in progress SHALL be aborted by rst, with no rdy pulse for it.

Configuration
- REQ-023: Macro BCD2BIN_ERRCHK_EN SHALL select digit checking.
- REQ-024: With BCD2BIN_ERRCHK_EN defined, an accepted start with any digit > 9 SHALL:
  - skip SHIFT/ADJ and go directly to DONE;
  - set bin=0 and err=1 with rdy, 2 cycles after the accepting edge;
  - a valid conversion SHALL set err=0.
- REQ-025: Without BCD2BIN_ERRCHK_EN, err SHALL be tied 0, and invalid digits SHALL run the normal 28-cycle sequence with a deterministic but unspecified bin.

Verification
- REQ-026: rst, then bcd=16'h1234 with start 1 cycle -> busy=1 next cycle, rdy=1 exactly 28 cycles after the start edge, bin=1234 (14'h04D2), err=0.
- REQ-027: bcd=16'h9999 -> bin=9999 (14'h270F); bcd=16'h0000 -> bin=0; bcd=16'h0001 -> bin=1.
- REQ-028: Second start with bcd=16'h0005 pulsed at cycle 10 of a 16'h0042 conversion -> single rdy with bin=42, no second rdy.
- REQ-029: start held high with bcd=16'h0100 -> rdy pulses every 29 cycles, bin=100 each time.
- REQ-030: rst asserted at cycle 15 of a conversion -> no rdy, outputs 0 next cycle; a new start then converts normally.
- REQ-031: With BCD2BIN_ERRCHK_EN, bcd=16'h12A4 -> rdy=1 2 cycles after start, err=1, bin=0; next bcd=16'h0007 -> err=0, bin=7.

Source files
------------

// File: rtl/bcd2bin.sv
// Purpose: converts four packed BCD digits to a 14-bit binary value by sequential reverse double-dabble.
// Latency: rdy pulses 28 cycles after the accepting start edge (2 cycles for a rejected input with BCD2BIN_ERRCHK_EN).
// Backpressure: start is sampled only while idle; requests during a conversion are dropped, never queued.
module bcd2bin (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bcd,
   input  logic        start,
   output logic [13:0] bin,
   output logic        busy,
   output logic        rdy,
   output logic        err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] ADJ   = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]  state;
   logic [29:0] work;      // {bcd digits [29:14], binary accumulator [13:0]}
   logic [3:0]  cnt;       // shifts completed so far
   logic [29:0] work_shr;
   logic [29:0] work_adj;

   // One right shift moves the lowest BCD bit into the binary accumulator.
   assign work_shr = {1'b0, work[29:1]};

   // Undo the implied doubling: any digit field that reached 8 or more had a borrow from above.
   always_comb begin
      work_adj = work;
      for (int i = 0; i < 4; i++) begin
         if (work[14 + 4*i +: 4] >= 4'd8)
            work_adj[14 + 4*i +: 4] = work[14 + 4*i +: 4] - 4'd3;
      end
   end

`ifdef BCD2BIN_ERRCHK_EN
   logic digit_bad;
   logic bad;

   // Flag any loaded digit outside 0..9; checked on the first SHIFT cycle only.
   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (work[14 + 4*i +: 4] > 4'd9)
            digit_bad = 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         work  <= '0;
         cnt   <= '0;
         bin   <= '0;
         busy  <= 1'b0;
         rdy   <= 1'b0;
`ifdef BCD2BIN_ERRCHK_EN
         err   <= 1'b0;
         bad   <= 1'b0;
`endif
      end else begin
         rdy <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  work  <= {bcd, 14'b0};
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
`ifdef BCD2BIN_ERRCHK_EN
                  bad   <= 1'b0;
`endif
               end
            end
            SHIFT: begin
`ifdef BCD2BIN_ERRCHK_EN
               // An invalid digit bypasses the whole shift/adjust sequence.
               if (cnt == 4'd0 && digit_bad) begin
                  bad   <= 1'b1;
                  state <= DONE;
               end else
`endif
               begin
                  work  <= work_shr;
                  cnt   <= cnt + 4'd1;
                  state <= (cnt == 4'd13) ? DONE : ADJ;
               end
            end
            ADJ: begin
               work  <= work_adj;
               state <= SHIFT;
            end
            DONE: begin
`ifdef BCD2BIN_ERRCHK_EN
               bin   <= bad ? 14'd0 : work[13:0];
               err   <= bad;
               bad   <= 1'b0;
`else
               bin   <= work[13:0];
`endif
               rdy   <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin.sv
// Purpose: self-checking bench for bcd2bin against an arithmetic reference model.
// Latency: checks the 28-cycle conversion (and 2-cycle rejection when BCD2BIN_ERRCHK_EN is defined).
// Backpressure: checks that starts during a conversion are dropped and a held start repeats every 29 cycles.
module tb_bcd2bin;

   logic        clk;
   logic        rst;
   logic [15:0] bcd;
   logic        start;
   logic [13:0] bin;
   logic        busy;
   logic        rdy;
   logic        err;

   int total = 0;
   int bad   = 0;

   bcd2bin dut (
      .clk   (clk),
      .rst   (rst),
      .bcd   (bcd),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .rdy   (rdy),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Reference: decimal value of the four digits.
   function automatic int ref_bin(input logic [15:0] b);
      return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   // Issue one start, then measure latency and result.
   task automatic run_conv(input string tag, input logic [15:0] b, input int exp_lat,
                           input logic chk_bin, input logic [13:0] exp_bin, input logic exp_err);
      int lat;
      @(negedge clk);
      bcd   = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bcd   = 16'($urandom);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      lat = 0;
      while (!rdy && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      if (chk_bin) chk({tag, "_bin"}, 32'(bin), 32'(exp_bin));
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, "_rdy_pulse"}, 32'(rdy), 32'd0);
      if (chk_bin) chk({tag, "_bin_hold"}, 32'(bin), 32'(exp_bin));
   endtask

   initial begin
      logic [15:0] rb;
      int          seen;
      int          n;
      int          last_t;
      int          t;

      rst   = 1'b1;
      start = 1'b0;
      bcd   = 16'h0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_bin",  32'(bin),  32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdy",  32'(rdy),  32'd0);
      chk("rst_err",  32'(err),  32'd0);

      // Directed values, including both range ends.
      run_conv("c1234", 16'h1234, 28, 1'b1, 14'(ref_bin(16'h1234)), 1'b0);
      run_conv("c9999", 16'h9999, 28, 1'b1, 14'(ref_bin(16'h9999)), 1'b0);
      run_conv("c0000", 16'h0000, 28, 1'b1, 14'(ref_bin(16'h0000)), 1'b0);
      run_conv("c0001", 16'h0001, 28, 1'b1, 14'(ref_bin(16'h0001)), 1'b0);

      // Random valid digits.
      for (int i = 0; i < 20; i++) begin
         for (int d = 0; d < 4; d++) rb[4*d +: 4] = 4'($urandom_range(0, 9));
         run_conv("rand", rb, 28, 1'b1, 14'(ref_bin(rb)), 1'b0);
      end

      // A second start mid-conversion is dropped.
      @(negedge clk);
      bcd   = 16'h0042;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!rdy && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 10) begin
            bcd   = 16'h0005;
            start = 1'b1;
         end else if (n == 11) begin
            start = 1'b0;
         end
      end
      chk("drop_lat", 32'(n), 32'd28);
      chk("drop_bin", 32'(bin), 32'(ref_bin(16'h0042)));
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (rdy) seen++;
      end
      chk("drop_no_second_rdy", 32'(seen), 32'd0);

      // Held start repeats every 29 cycles.
      @(negedge clk);
      bcd   = 16'h0100;
      start = 1'b1;
      seen   = 0;
      last_t = 0;
      t      = 0;
      while (seen < 3 && t < 120) begin
         @(negedge clk);
         t++;
         if (rdy) begin
            chk("held_bin", 32'(bin), 32'(ref_bin(16'h0100)));
            if (seen > 0) chk("held_period", 32'(t - last_t), 32'd29);
            else          chk("held_first_lat", 32'(t - 1), 32'd28);
            last_t = t;
            seen++;
            if (seen == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      chk("held_count", 32'(seen), 32'd3);

      // Reset aborts a conversion in progress.
      @(negedge clk);
      bcd   = 16'h1234;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_bin",  32'(bin),  32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rdy",  32'(rdy),  32'd0);
      chk("abort_err",  32'(err),  32'd0);
      seen = 0;
      repeat (35) begin
         @(negedge clk);
         if (rdy) seen++;
      end
      chk("abort_no_rdy", 32'(seen), 32'd0);
      run_conv("after_abort", 16'h0678, 28, 1'b1, 14'(ref_bin(16'h0678)), 1'b0);

      // Invalid digit handling.
`ifdef BCD2BIN_ERRCHK_EN
      run_conv("inv", 16'h12A4, 2, 1'b1, 14'd0, 1'b1);
      run_conv("inv_next", 16'h0007, 28, 1'b1, 14'(ref_bin(16'h0007)), 1'b0);
`else
      run_conv("inv", 16'h12A4, 28, 1'b0, 14'd0, 1'b0);
      run_conv("inv_next", 16'h0007, 28, 1'b1, 14'(ref_bin(16'h0007)), 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
